// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one imem request at a time and buffers the word for decode.
// Optional macro IFU_MISALIGN_CHK_EN: raise a misaligned-fetch fault instead of forcing PC[1:0] to zero.
`ifndef XLEN
`define XLEN 32
`endif

module ifu_fetch #(
  parameter logic [`XLEN-1:0] RESET_PC = `XLEN'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [`XLEN-1:0]  redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [`XLEN-1:0]  imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [`XLEN-1:0]  inst_pc,
  output logic              inst_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [`XLEN-1:0]  pc_q, pc_d;
  logic [`XLEN-1:0]  inst_pc_q, inst_pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              misalign_q, misalign_d;
  logic              pc_misaligned;

  function automatic logic [`XLEN-1:0] align_pc(input logic [`XLEN-1:0] pc);
`ifdef IFU_MISALIGN_CHK_EN
    return pc;
`else
    return {pc[`XLEN-1:2], 2'b00};
`endif
  endfunction

`ifdef IFU_MISALIGN_CHK_EN
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    misalign_d     = misalign_q;
    imem_req_valid = 1'b0;

    case (state_q)
      S_REQ: begin
        imem_req_valid = !redirect_valid && !pc_misaligned;
        if (redirect_valid) begin
          pc_d = align_pc(redirect_pc);
        end else if (pc_misaligned) begin
          // Fault takes the instruction slot without touching memory.
          state_d    = S_HOLD;
          inst_d     = NOP;
          inst_pc_d  = pc_q;
          misalign_d = 1'b1;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = align_pc(redirect_pc);
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          state_d    = S_HOLD;
          inst_d     = imem_resp_data;
          inst_pc_d  = pc_q;
          misalign_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = align_pc(redirect_pc);
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = align_pc(pc_q + `XLEN'(4));
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // The killed response must still drain before a new request may go out.
        if (redirect_valid) pc_d = align_pc(redirect_pc);
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (rst) imem_req_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= align_pc(RESET_PC);
      inst_q     <= NOP;
      inst_pc_q  <= align_pc(RESET_PC);
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign inst_valid    = (state_q == S_HOLD);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_misalign = misalign_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: sequential fetch, decode stall, redirects in each state, misalign, reset.
`ifndef XLEN
`define XLEN 32
`endif

module tb_ifu_fetch;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect_valid;
  logic [`XLEN-1:0]  redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [`XLEN-1:0]  imem_req_addr;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [`XLEN-1:0]  inst_pc;
  logic              inst_misalign;

  int n_checks = 0;
  int n_errors = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_misalign  (inst_misalign)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b1;
  endtask

  // Starts and ends just after an edge with the DUT in REQ; stalls decode for 'stall' HOLD cycles.
  task automatic fetch(input logic [31:0] data, input logic [`XLEN-1:0] pc, input int stall);
    drive_idle();
    #1;
    check_eq("req_valid", imem_req_valid, 1);
    check_eq("req_addr", imem_req_addr, pc);
    check_eq("inst_valid_in_req", inst_valid, 0);
    next_cycle();
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    #1;
    check_eq("req_valid_in_wait", imem_req_valid, 0);
    next_cycle();
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      check_eq("stall_inst_valid", inst_valid, 1);
      check_eq("stall_inst", inst, data);
      check_eq("stall_inst_pc", inst_pc, pc);
      check_eq("stall_no_req", imem_req_valid, 0);
      next_cycle();
    end
    inst_ready = 1'b1;
    #1;
    check_eq("inst_valid", inst_valid, 1);
    check_eq("inst", inst, data);
    check_eq("inst_pc", inst_pc, pc);
    check_eq("inst_misalign", inst_misalign, 0);
    next_cycle();
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    #1;
    check_eq("req_valid_during_rst", imem_req_valid, 0);
    next_cycle();
    next_cycle();
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_inst", inst, 32'h0000_0013);
    check_eq("rst_inst_pc", inst_pc, 32'h8000_0000);
    check_eq("rst_misalign", inst_misalign, 0);
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_req_addr", imem_req_addr, 32'h8000_0000);
    rst = 1'b0;

    // Sequential fetches with zero-wait memory, then a 5-cycle decode stall
    fetch(32'h1111_0001, 32'h8000_0000, 0);
    fetch(32'h1111_0002, 32'h8000_0004, 0);
    fetch(32'h1111_0003, 32'h8000_0008, 0);
    fetch(32'h1111_0004, 32'h8000_000C, 5);

    // Redirect in WAIT; the killed response arrives two cycles later
    drive_idle();
    #1;
    check_eq("req_addr_after_stall", imem_req_addr, 32'h8000_0010);
    check_eq("req_valid_after_stall", imem_req_valid, 1);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    #1;
    check_eq("no_req_in_wait", imem_req_valid, 0);
    next_cycle();
    drive_idle();
    #1;
    check_eq("drop_no_req", imem_req_valid, 0);
    check_eq("drop_inst_valid", inst_valid, 0);
    next_cycle();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    #1;
    check_eq("drop_resp_inst_valid", inst_valid, 0);
    next_cycle();
    fetch(32'h2222_2222, 32'h8000_0100, 0);

    // Redirect in HOLD together with inst_ready
    drive_idle();
    #1;
    check_eq("req_addr_104", imem_req_addr, 32'h8000_0104);
    next_cycle();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h3333_3333;
    next_cycle();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h8000_0200;
    inst_ready      = 1'b1;
    #1;
    check_eq("hold_inst", inst, 32'h3333_3333);
    check_eq("hold_inst_valid", inst_valid, 1);
    next_cycle();
    drive_idle();
    #1;
    check_eq("hold_redir_inst_valid", inst_valid, 0);
    check_eq("hold_redir_req_valid", imem_req_valid, 1);
    check_eq("hold_redir_addr", imem_req_addr, 32'h8000_0200);

    // Redirect in WAIT in the same cycle as the response
    next_cycle();
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h8000_0300;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    next_cycle();
    drive_idle();
    #1;
    check_eq("wait_resp_redir_req_valid", imem_req_valid, 1);
    check_eq("wait_resp_redir_addr", imem_req_addr, 32'h8000_0300);
    check_eq("wait_resp_redir_inst_valid", inst_valid, 0);
    fetch(32'h4444_4444, 32'h8000_0300, 0);

    // PC wrap past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    check_eq("no_req_on_redirect_in_req", imem_req_valid, 0);
    next_cycle();
    fetch(32'h6666_6666, 32'hFFFF_FFFC, 0);
    drive_idle();
    #1;
    check_eq("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Redirect to a misaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    next_cycle();
    drive_idle();
    #1;
`ifdef IFU_MISALIGN_CHK_EN
    check_eq("misalign_no_req", imem_req_valid, 0);
    next_cycle();
    check_eq("misalign_inst_valid", inst_valid, 1);
    check_eq("misalign_flag", inst_misalign, 1);
    check_eq("misalign_inst_pc", inst_pc, 32'h8000_0102);
    check_eq("misalign_inst", inst, 32'h0000_0013);
    check_eq("misalign_hold_no_req", imem_req_valid, 0);
`else
    check_eq("aligned_req_valid", imem_req_valid, 1);
    check_eq("aligned_req_addr", imem_req_addr, 32'h8000_0100);
    check_eq("aligned_misalign", inst_misalign, 0);
    fetch(32'h5555_5555, 32'h8000_0100, 0);
`endif

    // Reset mid-operation; a stale response after reset is ignored
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h7777_7777;
    #1;
    check_eq("post_rst_req_valid", imem_req_valid, 1);
    check_eq("post_rst_req_addr", imem_req_addr, 32'h8000_0000);
    check_eq("post_rst_inst_valid", inst_valid, 0);
    next_cycle();
    imem_resp_valid = 1'b0;
    #1;
    check_eq("post_rst_wait_inst_valid", inst_valid, 0);
    check_eq("post_rst_wait_no_req", imem_req_valid, 0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h8888_8888;
    next_cycle();
    drive_idle();
    #1;
    check_eq("post_rst_inst_valid_hold", inst_valid, 1);
    check_eq("post_rst_inst", inst, 32'h8888_8888);
    check_eq("post_rst_inst_pc", inst_pc, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
